// File: rtl/scroll_addr_gen.sv
// scroll_addr_gen
//   Turns screen raster coordinates into source-image memory addresses for a
//   wrapping scroller. The screen is downscaled by SCALE_SH into an IMG_W x
//   IMG_H source image, and per-frame x/y offsets scroll that image with
//   wrap-around. Offsets only move on frame_start, so every frame is drawn
//   with one constant pair of offsets.
//
//   Build option: define SCROLL_ADDR_PIPE_EN to split the multiply and the add
//   into two register stages. pixel_addr/addr_valid latency then becomes
//   2 pclk instead of 1. Nothing else changes.
//
// Ports
//   pclk, rst          pixel clock; asynchronous active-high reset
//   frame_start        one-cycle pulse at the first cycle of each frame
//   valid_in           screen pixel visible this cycle
//   h_cnt, v_cnt       screen column / line
//   en                 scroll enable (0 freezes frame counter and offsets)
//   mode               0 static, 1 up, 2 down, 3 left, 4 right, 5..7 static
//   speed              source pixels moved per step
//   frame_div          frames per step minus one
//   pixel_addr         src_y*IMG_W + src_x, forced to 0 while addr_valid = 0
//   addr_valid         valid_in delayed to line up with pixel_addr
//   x_off, y_off       current scroll offsets
//   wrap               one-cycle pulse when a step wrapped an offset
module scroll_addr_gen #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int SCALE_SH = 1,
    parameter int ADDR_W   = 17,
    parameter int STEP_W   = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              valid_in,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [STEP_W-1:0] speed,
    input  logic [3:0]        frame_div,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              addr_valid,
    output logic [9:0]        x_off,
    output logic [8:0]        y_off,
    output logic              wrap
);

    localparam logic [2:0] MODE_UP    = 3'd1;
    localparam logic [2:0] MODE_DOWN  = 3'd2;
    localparam logic [2:0] MODE_LEFT  = 3'd3;
    localparam logic [2:0] MODE_RIGHT = 3'd4;

    localparam logic [10:0]       XW11   = 11'(IMG_W);
    localparam logic [9:0]        XW10   = 10'(IMG_W);
    localparam logic [9:0]        XMAX10 = 10'(IMG_W - 1);
    localparam logic [9:0]        YH10   = 10'(IMG_H);
    localparam logic [8:0]        YH9    = 9'(IMG_H);
    localparam logic [8:0]        YMAX9  = 9'(IMG_H - 1);
    localparam logic [15:0]       XMAX16 = 16'(IMG_W - 1);
    localparam logic [15:0]       YMAX16 = 16'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] A_IMGW = ADDR_W'(IMG_W);

    // ------------------------------------------------------------------
    // Scroll state
    // ------------------------------------------------------------------
    logic [9:0]        r_x_off;
    logic [8:0]        r_y_off;
    logic [3:0]        r_fcnt;
    logic [2:0]        r_mode;
    logic [STEP_W-1:0] r_speed;
    logic [3:0]        r_fdiv;
    logic              r_wrap;

    // The config sampled at a frame_start already governs the step issued on
    // that same frame_start; between frame_starts the shadows hold it.
    logic [2:0]        w_mode;
    logic [STEP_W-1:0] w_speed;
    logic [3:0]        w_fdiv;
    assign w_mode  = frame_start ? mode      : r_mode;
    assign w_speed = frame_start ? speed     : r_speed;
    assign w_fdiv  = frame_start ? frame_div : r_fdiv;

    logic w_cnt_hit;
    logic w_step;
    assign w_cnt_hit = (r_fcnt >= w_fdiv);
    assign w_step    = frame_start && en && w_cnt_hit;

    // Speed clamped separately per axis so a step never exceeds one image.
    logic [15:0] w_spd16;
    logic [9:0]  w_spd_x;
    logic [8:0]  w_spd_y;
    assign w_spd16 = 16'(w_speed);
    assign w_spd_x = (w_spd16 > XMAX16) ? XMAX10 : w_spd16[9:0];
    assign w_spd_y = (w_spd16 > YMAX16) ? YMAX9  : w_spd16[8:0];

    logic [10:0] w_xinc;
    logic [9:0]  w_yinc;
    assign w_xinc = {1'b0, r_x_off} + {1'b0, w_spd_x};
    assign w_yinc = {1'b0, r_y_off} + {1'b0, w_spd_y};

    logic [9:0] w_x_nxt;
    logic [8:0] w_y_nxt;
    logic       w_wrap;

    // Results are always < IMG_W / IMG_H, so the narrow modular arithmetic
    // below lands on the right value even when intermediate terms overflow.
    always_comb begin
        w_x_nxt = r_x_off;
        w_y_nxt = r_y_off;
        w_wrap  = 1'b0;
        case (w_mode)
            MODE_UP: begin
                if (w_yinc >= YH10) begin
                    w_y_nxt = w_yinc[8:0] - YH9;
                    w_wrap  = 1'b1;
                end else begin
                    w_y_nxt = w_yinc[8:0];
                end
            end
            MODE_DOWN: begin
                if (r_y_off < w_spd_y) begin
                    w_y_nxt = r_y_off + YH9 - w_spd_y;
                    w_wrap  = 1'b1;
                end else begin
                    w_y_nxt = r_y_off - w_spd_y;
                end
            end
            MODE_LEFT: begin
                if (w_xinc >= XW11) begin
                    w_x_nxt = w_xinc[9:0] - XW10;
                    w_wrap  = 1'b1;
                end else begin
                    w_x_nxt = w_xinc[9:0];
                end
            end
            MODE_RIGHT: begin
                if (r_x_off < w_spd_x) begin
                    w_x_nxt = r_x_off + XW10 - w_spd_x;
                    w_wrap  = 1'b1;
                end else begin
                    w_x_nxt = r_x_off - w_spd_x;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_x_off <= '0;
            r_y_off <= '0;
            r_fcnt  <= '0;
            r_mode  <= '0;
            r_speed <= '0;
            r_fdiv  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_step && w_wrap;
            if (frame_start) begin
                r_mode  <= mode;
                r_speed <= speed;
                r_fdiv  <= frame_div;
                if (en) begin
                    r_fcnt <= w_cnt_hit ? 4'd0 : r_fcnt + 4'd1;
                end
            end
            if (w_step) begin
                r_x_off <= w_x_nxt;
                r_y_off <= w_y_nxt;
            end
        end
    end

    assign x_off = r_x_off;
    assign y_off = r_y_off;
    assign wrap  = r_wrap;

    // ------------------------------------------------------------------
    // Pixel address path
    // ------------------------------------------------------------------
    logic [9:0]  w_hs;
    logic [9:0]  w_hc;
    logic [10:0] w_sxs;
    logic [9:0]  w_src_x;
    logic [9:0]  w_vs;
    logic [8:0]  w_vc;
    logic [9:0]  w_sys;
    logic [8:0]  w_src_y;

    // Clamp out-of-range screen coordinates first so one conditional
    // subtract is enough to fold the offset sum back into the image.
    assign w_hs    = h_cnt >> SCALE_SH;
    assign w_hc    = (w_hs > XMAX10) ? XMAX10 : w_hs;
    assign w_sxs   = {1'b0, w_hc} + {1'b0, r_x_off};
    assign w_src_x = (w_sxs >= XW11) ? w_sxs[9:0] - XW10 : w_sxs[9:0];

    assign w_vs    = v_cnt >> SCALE_SH;
    assign w_vc    = (w_vs > {1'b0, YMAX9}) ? YMAX9 : w_vs[8:0];
    assign w_sys   = {1'b0, w_vc} + {1'b0, r_y_off};
    assign w_src_y = (w_sys >= YH10) ? w_sys[8:0] - YH9 : w_sys[8:0];

    logic [ADDR_W-1:0] w_prod;
    assign w_prod = ADDR_W'(w_src_y) * A_IMGW;

    logic [ADDR_W-1:0] r_addr;
    logic              r_av;

`ifdef SCROLL_ADDR_PIPE_EN
    logic [ADDR_W-1:0] r_prod;
    logic [9:0]        r_sx;
    logic              r_v1;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_sx   <= '0;
            r_v1   <= 1'b0;
            r_addr <= '0;
            r_av   <= 1'b0;
        end else begin
            r_v1   <= valid_in;
            r_prod <= valid_in ? w_prod  : '0;
            r_sx   <= valid_in ? w_src_x : '0;
            r_av   <= r_v1;
            r_addr <= r_v1 ? r_prod + ADDR_W'(r_sx) : '0;
        end
    end
`else
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_av   <= 1'b0;
        end else begin
            r_av   <= valid_in;
            r_addr <= valid_in ? w_prod + ADDR_W'(w_src_x) : '0;
        end
    end
`endif

    assign pixel_addr = r_addr;
    assign addr_valid = r_av;

endmodule

// File: tb/tb_scroll_addr_gen.sv
// Directed bench for scroll_addr_gen (default 320x240 image, SCALE_SH 1).
// Inputs are driven and outputs sampled on the falling edge of pclk.
module tb_scroll_addr_gen;

`ifdef SCROLL_ADDR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        pclk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        valid_in;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        en;
    logic [2:0]  mode;
    logic [3:0]  speed;
    logic [3:0]  frame_div;
    logic [16:0] pixel_addr;
    logic        addr_valid;
    logic [9:0]  x_off;
    logic [8:0]  y_off;
    logic        wrap;

    int n_vec = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    scroll_addr_gen dut (
        .pclk       (pclk),
        .rst        (rst),
        .frame_start(frame_start),
        .valid_in   (valid_in),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .en         (en),
        .mode       (mode),
        .speed      (speed),
        .frame_div  (frame_div),
        .pixel_addr (pixel_addr),
        .addr_valid (addr_valid),
        .x_off      (x_off),
        .y_off      (y_off),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    // One-cycle frame_start; returns on the next falling edge.
    task automatic fs();
        frame_start = 1'b1;
        @(negedge pclk);
        frame_start = 1'b0;
    endtask

    task automatic px(input string tag, input int h, input int v, input int exp);
        valid_in = 1'b1;
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        nclk(LAT);
        chk({tag, "_addr"}, int'(pixel_addr), exp);
        chk({tag, "_av"}, int'(addr_valid), 1);
        valid_in = 1'b0;
        nclk(LAT);
        chk({tag, "_idle_addr"}, int'(pixel_addr), 0);
        chk({tag, "_idle_av"}, int'(addr_valid), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, int'(pixel_addr), 0);
        chk({tag, "_av"}, int'(addr_valid), 0);
        chk({tag, "_x"}, int'(x_off), 0);
        chk({tag, "_y"}, int'(y_off), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; valid_in = 1'b0;
        h_cnt = '0; v_cnt = '0; en = 1'b0;
        mode = '0; speed = '0; frame_div = '0;
        nclk(2);
        rst = 1'b0;
        nclk(1);
        chk_all_zero("reset");

        // (10>>1)+0, (6>>1)+0 -> 3*320+5
        px("static", 10, 6, 965);

        // up by 3, five steps
        en = 1'b1; mode = 3'd1; speed = 4'd3; frame_div = 4'd0;
        repeat (5) fs();
        chk("up5_y", int'(y_off), 15);
        chk("up5_wrap", int'(wrap), 0);
        // down 15 lands exactly on 0 from above: no wrap
        mode = 3'd2; speed = 4'd15;
        fs();
        chk("down_to0_y", int'(y_off), 0);
        chk("down_to0_wrap", int'(wrap), 0);
        // down 2 from 0 -> 238
        speed = 4'd2;
        fs();
        chk("down_wrap_y", int'(y_off), 238);
        chk("down_wrap_pulse", int'(wrap), 1);
        nclk(1);
        chk("down_wrap_clr", int'(wrap), 0);
        // up 3 from 238 -> 1
        mode = 3'd1; speed = 4'd3;
        fs();
        chk("up_wrap_y", int'(y_off), 1);
        chk("up_wrap_pulse", int'(wrap), 1);
        nclk(1);
        chk("up_wrap_clr", int'(wrap), 0);

        // left 2 then right 5: 2 - 5 -> 317
        mode = 3'd3; speed = 4'd2;
        fs();
        chk("left_x", int'(x_off), 2);
        chk("left_wrap", int'(wrap), 0);
        mode = 3'd4; speed = 4'd5;
        fs();
        chk("right_wrap_x", int'(x_off), 317);
        chk("right_wrap_pulse", int'(wrap), 1);
        chk("right_y_kept", int'(y_off), 1);
        px("org", 0, 0, 320 * 1 + 317);
        // src_x = 5+317-320 = 2, src_y = 3+1 = 4
        px("xfold", 10, 6, 4 * 320 + 2);
        // src_x = 319+317-320 = 316, src_y = 239+1-240 = 0
        px("corner", 639, 479, 316);

        // speed 0 step: no change, no wrap
        speed = 4'd0;
        fs();
        chk("spd0_x", int'(x_off), 317);
        chk("spd0_wrap", int'(wrap), 0);

        // asynchronous reset mid-frame
        valid_in = 1'b1; h_cnt = 10'd10; v_cnt = 10'd6;
        nclk(LAT);
        chk("pre_rst_addr", int'(pixel_addr), 1282);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        valid_in = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        mode = 3'd3; speed = 4'd1; frame_div = 4'd2;
        nclk(3);
        chk("post_rst_addr", int'(pixel_addr), 0);
        chk("post_rst_av", int'(addr_valid), 0);
        chk("post_rst_x", int'(x_off), 0);

        // left 1 every 3rd frame
        fs(); fs();
        chk("div2_2fs_x", int'(x_off), 0);
        fs();
        chk("div2_3fs_x", int'(x_off), 1);
        fs(); fs(); fs();
        chk("div2_6fs_x", int'(x_off), 2);

        // mid-frame config change does nothing until next frame_start
        mode = 3'd2; frame_div = 4'd0;
        nclk(5);
        chk("midframe_x", int'(x_off), 2);
        chk("midframe_y", int'(y_off), 0);
        fs();
        chk("newframe_y", int'(y_off), 239);
        chk("newframe_wrap", int'(wrap), 1);
        chk("newframe_x", int'(x_off), 2);

        // counter to 1, then frozen by en=0 for 4 frames
        mode = 3'd3; frame_div = 4'd2;
        fs();
        chk("cnt1_x", int'(x_off), 2);
        en = 1'b0;
        repeat (4) fs();
        chk("en0_x", int'(x_off), 2);
        chk("en0_y", int'(y_off), 239);
        chk("en0_wrap", int'(wrap), 0);
        en = 1'b1;
        fs();
        chk("en1_cnt2_x", int'(x_off), 2);
        fs();
        chk("en1_step_x", int'(x_off), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scroll_addr_gen.md
SCROLL_ADDR_GEN -- requirements
Module: scroll_addr_gen

Interface
REQ-001 Parameter IMG_W, default 320, source image width in pixels.
REQ-002 Parameter IMG_H, default 240, source image height in lines.
REQ-003 Parameter SCALE_SH, default 1, screen-to-source downscale shift (0..2).
REQ-004 Parameter ADDR_W, default 17, pixel address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 Parameter STEP_W, default 4, width of speed input.
REQ-006 pclk  input  1  pixel clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 frame_start  input  1  one-pclk pulse at the first cycle of each frame.
REQ-009 valid_in  input  1  screen pixel visible this cycle.
REQ-010 h_cnt  input  10  screen column, 0..639.
REQ-011 v_cnt  input  10  screen line, 0..479.
REQ-012 en  input  1  scroll enable; 0 freezes offsets.
REQ-013 mode  input  3  0 static, 1 up, 2 down, 3 left, 4 right, 5..7 treated as static.
REQ-014 speed  input  STEP_W  source pixels moved per step.
REQ-015 frame_div  input  4  frames per step minus one (0 = step every frame).
REQ-016 pixel_addr  output  ADDR_W  source memory address.
REQ-017 addr_valid  output  1  valid_in delayed to align with pixel_addr.
REQ-018 x_off  output  10  current horizontal offset, 0..IMG_W-1.
REQ-019 y_off  output  9  current vertical offset, 0..IMG_H-1.
REQ-020 wrap  output  1  one-pclk pulse when an offset update wraps.

Function
REQ-021 src_x = ((h_cnt>>SCALE_SH) + x_off) reduced into 0..IMG_W-1 by a single conditional subtract of IMG_W; no divider/modulo operator.
REQ-022 src_y = ((v_cnt>>SCALE_SH) + y_off) reduced into 0..IMG_H-1 the same way; inputs beyond the source range clamp to IMG_W-1/IMG_H-1 before addition.
REQ-023 pixel_addr = src_y*IMG_W + src_x, registered; latency 1 pclk from h_cnt/v_cnt/valid_in; addr_valid carries the same latency.
REQ-024 When addr_valid = 0, pixel_addr SHALL be 0.
REQ-025 mode, speed, frame_div SHALL be sampled only on frame_start into shadow registers; changes mid-frame have no effect until the next frame.
REQ-026 Frame counter counts frame_start pulses while en = 1; on reaching shadow frame_div it resets to 0 and issues one step in the same cycle.
REQ-027 Step: up y_off += speed; down y_off -= speed; left x_off += speed; right x_off -= speed; static no change; speed clamped to IMG_W-1 (x) or IMG_H-1 (y).
REQ-028 Step results wrap modulo IMG_W/IMG_H; wrap SHALL pulse one pclk after any step whose result wrapped, including exact hit of 0 from below.
REQ-029 Offsets update only at frame_start, so a whole frame uses constant offsets.
REQ-030 en = 0 holds frame counter and offsets; en deasserted on a frame_start cycle blocks that step.
REQ-031 speed = 0 steps occur but change nothing and never pulse wrap.

Reset
REQ-032 rst SHALL asynchronously clear x_off, y_off, frame counter, shadow registers (mode static, speed 0, frame_div 0), pixel pipeline, pixel_addr, addr_valid, wrap.
REQ-033 Reset mid-frame: after release, outputs stay 0 until valid_in is sampled; stepping resumes only after the next frame_start.

Configuration
REQ-034 Macro SCROLL_ADDR_PIPE_EN defined: an extra register stage splits the multiply and the add; latency 2 pclk for pixel_addr and addr_valid.
REQ-035 SCROLL_ADDR_PIPE_EN undefined: latency 1 pclk per REQ-023; all other behaviour identical.

Verification
REQ-036 Reset, mode 0, h_cnt=10, v_cnt=6, valid_in=1 -> pixel_addr = 3*320+5 = 965 after 1 pclk (2 with macro).
REQ-037 mode 1, speed 3, frame_div 0, en 1, five frame_start pulses -> y_off = 15; with y_off 238 next step -> y_off 1, wrap pulses once.
REQ-038 mode 4, speed 5, x_off 2, one step -> x_off 317, wrap pulse; h_cnt=0, v_cnt=0 -> pixel_addr = 320*y_off+317.
REQ-039 frame_div 2, mode 3, speed 1, six frame_start pulses -> x_off = 2; mode changed to 2 mid-frame -> no effect until next frame_start.
REQ-040 en 0 for 4 frame_starts -> offsets and frame counter unchanged; rst asserted mid-frame -> all outputs 0 immediately, asynchronous to pclk.
